// File: rtl/num_ascii_streamer.sv
// num_ascii_streamer: binary to decimal ASCII streamer; define NUM_ASCII_CRLF_EN to append CR LF
module num_ascii_streamer #(
  parameter int WIDTH = 14,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = DIGITS > 1 ? $clog2(DIGITS) : 1;
`ifdef NUM_ASCII_CRLF_EN
  typedef enum logic [2:0] {IDLE, CONV, SEND, DONE, CR, LF} state_t;
`else
  typedef enum logic [1:0] {IDLE, CONV, SEND, DONE} state_t;
`endif
  state_t state, nxt;
  logic [WIDTH-1:0] bin;
  logic [4*DIGITS-1:0] bcd, adj, shf;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr, msd;
  logic [3:0] dig [DIGITS];
  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_dig
    assign dig[i] = bcd[4*i +: 4];
  end
  // one double-dabble step, plus the leading digit of its result for the pointer load
  always_comb begin
    adj = bcd;
    msd = '0;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k +: 4] = bcd[4*k +: 4] >= 4'd5 ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
    shf = {adj[4*DIGITS-2:0], bin[WIDTH-1]};
    for (int k = 0; k < DIGITS; k++)
      if (shf[4*k +: 4] != 4'd0) msd = PW'(k);
  end
  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? CONV : IDLE;
      CONV: nxt = cnt == CW'(1) ? SEND : CONV;
`ifdef NUM_ASCII_CRLF_EN
      SEND: nxt = out_ready && ptr == '0 ? CR : SEND;
      CR:   nxt = out_ready ? LF : CR;
      LF:   nxt = out_ready ? DONE : LF;
`else
      SEND: nxt = out_ready && ptr == '0 ? DONE : SEND;
`endif
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state register and conversion datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      ptr <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        bin <= value;
        bcd <= '0;
        cnt <= CW'(WIDTH);
      end
      if (state == CONV) begin
        bcd <= shf;
        bin <= bin << 1;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) ptr <= msd;
      end
      if (state == SEND && out_ready && ptr != '0) ptr <= ptr - PW'(1);
    end
  end
  // character output, held by the registers while stalled
  always_comb begin
    out_data = 8'h00;
    if (state == SEND) out_data = {4'h3, dig[ptr]};
`ifdef NUM_ASCII_CRLF_EN
    if (state == CR) out_data = 8'h0D;
    if (state == LF) out_data = 8'h0A;
`endif
  end
`ifdef NUM_ASCII_CRLF_EN
  assign out_valid = state == SEND || state == CR || state == LF;
`else
  assign out_valid = state == SEND;
`endif
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_num_ascii_streamer.sv
// tb_num_ascii_streamer: directed checks of the decimal ASCII streamer
module tb_num_ascii_streamer;
  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic [13:0] value = '0;
  logic busy, out_valid, out_ready = 0, done;
  logic [7:0] out_data;
  int total = 0;
  int bad = 0;
  num_ascii_streamer dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .busy(busy),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [13:0] v, input string s, input logic [3:0] pat, input bit poke);
    string e;
    int n, idx, r;
    e = s;
`ifdef NUM_ASCII_CRLF_EN
    e = {s, "\r\n"};
`endif
    @(negedge clk);
    start = 1;
    value = v;
    out_ready = 0;
    @(negedge clk);
    start = 0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 15);
    idx = 0;
    r = 0;
    while (idx < e.len() && r < 200) begin
      out_ready = pat[r % 4];
      start = poke && r == 0;
      if (start) value = 14'd77;
      chk("valid", 32'(out_valid), 1);
      chk("data", 32'(out_data), 32'(e.getc(idx)));
      chk("no_done", 32'(done), 0);
      if (out_ready) idx++;
      r++;
      @(negedge clk);
    end
    out_ready = 0;
    start = 0;
    chk("chars", idx, e.len());
    chk("done", 32'(done), 1);
    chk("valid_off", 32'(out_valid), 0);
    chk("data_off", 32'(out_data), 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("idle", 32'(busy), 0);
    @(negedge clk);
    chk("stay_idle", 32'(busy), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_done", 32'(done), 0);
    reset = 0;
    run(14'd0, "0", 4'b1111, 0);
    run(14'd1234, "1234", 4'b1111, 0);
    run(14'd16383, "16383", 4'b1001, 0);
    run(14'd5, "5", 4'b1110, 1);
    run(14'd1000, "1000", 4'b1111, 0);
    run(14'd10, "10", 4'b0101, 0);
    run(14'd42, "42", 4'b1111, 0);
    @(negedge clk);
    start = 1;
    value = 14'd1234;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
    chk("r_first", 32'(out_data), 32'h31);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    @(negedge clk);
    chk("r_stall", 32'(out_data), 32'h32);
    reset = 1;
    out_ready = 1;
    start = 1;
    @(negedge clk);
    reset = 0;
    out_ready = 0;
    start = 0;
    chk("r_busy", 32'(busy), 0);
    chk("r_valid", 32'(out_valid), 0);
    chk("r_data", 32'(out_data), 0);
    chk("r_done", 32'(done), 0);
    @(negedge clk);
    chk("r_no_done", 32'(done), 0);
    chk("r_still_idle", 32'(busy), 0);
    run(14'd9, "9", 4'b1111, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/num_ascii_streamer.md
NUM_ASCII_STREAMER -- requirements
Module: num_ascii_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 14: bit width of the binary input value.
REQ-002 SHALL have parameter DIGITS, default 5: number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to convert and stream value; sampled only in IDLE.
REQ-006 SHALL have port value, input, WIDTH: unsigned binary number, captured on the edge that accepts start.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port out_valid, output, 1: out_data holds a character to transmit.
REQ-009 SHALL have port out_data, output, 8: ASCII character (digit = 0x30 + BCD digit).
REQ-010 SHALL have port out_ready, input, 1: downstream (UART TX) accepts the character.
REQ-011 SHALL have port done, output, 1: single-cycle pulse after the last character is accepted.

Function
REQ-012 SHALL implement states IDLE, CONV, SEND, DONE (plus CR, LF per REQ-026).
REQ-013 SHALL, in IDLE with start=1, capture value, clear the BCD register, load a shift counter with WIDTH, and enter CONV.
REQ-014 SHALL, in CONV, perform one sequential double-dabble iteration per cycle (add 3 to each BCD digit >= 5, then shift left one bit, MSB of value into BCD LSB), exactly WIDTH cycles.
REQ-015 SHALL, on leaving CONV, set the digit pointer to the most significant nonzero digit, or to digit 0 if all digits are zero, and enter SEND.
REQ-016 SHALL raise out_valid in the first cycle of SEND, i.e. WIDTH+1 cycles after the edge that accepted start.
REQ-017 SHALL transfer a character only on a cycle with out_valid=1 and out_ready=1 (handshake).
REQ-018 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, on each handshake in SEND, step the pointer to the next lower digit and present it the following cycle; no idle cycle between characters when out_ready stays high.
REQ-020 SHALL, on the handshake of digit 0, leave SEND (to CR if enabled, else DONE).
REQ-021 SHALL never emit leading zeros; value 0 emits exactly one character 0x30.
REQ-022 SHALL keep out_valid=0 in IDLE, CONV, DONE; out_data is 0x00 whenever out_valid=0.
REQ-023 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE (busy=0 the following cycle).
REQ-024 SHALL ignore start while busy=1; value changes during busy have no effect.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, in any state including mid-CONV or mid-SEND with a stalled character, enter IDLE with busy=0, out_valid=0, out_data=0x00, done=0, BCD and counters cleared; reset takes priority over start and out_ready; no partial character or done pulse follows.

Configuration
REQ-026 SHALL, with macro NUM_ASCII_CRLF_EN defined, after the final digit emit 0x0D (state CR) then 0x0A (state LF) under the same handshake rules before DONE.
REQ-027 SHALL, without NUM_ASCII_CRLF_EN, omit the CR/LF states and go from the last digit handshake directly to DONE.

Verification
REQ-028 SHALL cover: value=0, out_ready=1 -> single char 0x30 at cycle 15 after start, done one cycle after handshake.
REQ-029 SHALL cover: value=1234, out_ready=1 -> 0x31,0x32,0x33,0x34 on consecutive cycles, then done pulse; no 0x30 prefix.
REQ-030 SHALL cover: value=16383, out_ready toggling 1-0-0-1 -> 0x31,0x36,0x33,0x38,0x33 each held stable during stalls, none lost or duplicated.
REQ-031 SHALL cover: start=1 with value=77 pulsed during SEND of value 5 -> output only 0x35, second start ignored.
REQ-032 SHALL cover: reset asserted while 0x32 of 1234 is stalled -> next cycle busy=0, out_valid=0, out_data=0x00; fresh start of 9 -> 0x39.
REQ-033 SHALL cover: NUM_ASCII_CRLF_EN defined, value=42 -> 0x34,0x32,0x0D,0x0A, then done.
